// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, synchronous instruction-memory port and a small FIFO feeding decode.
// Optional performance counters are enabled by defining IF_PERF_CNT_EN.
module instruction_fetch_unit #(
    parameter int                  PC_WIDTH      = 32,
    parameter int                  IM_ADDR_WIDTH = 11,
    parameter int                  INSTR_WIDTH   = 32,
    parameter int                  BUF_DEPTH     = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC      = '0,
    parameter logic [PC_WIDTH-1:0] PC_STEP       = PC_WIDTH'(1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [PC_WIDTH-1:0]      redirect_pc,
    input  logic                     id_ready,
    output logic                     if_valid,
    output logic [INSTR_WIDTH-1:0]   if_instr,
    output logic [PC_WIDTH-1:0]      if_pc,
    output logic [PC_WIDTH-1:0]      if_pc_next,
    output logic                     im_cen,
    output logic                     im_wen,
    output logic                     im_oen,
    output logic [IM_ADDR_WIDTH-1:0] im_addr,
    output logic [INSTR_WIDTH-1:0]   im_datain,
    input  logic [INSTR_WIDTH-1:0]   im_dataout
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_bubble_cnt
`endif
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [PC_WIDTH-1:0]    tag_q, tag_d;
    logic                   inflight_q, inflight_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W:0]         credit;
    logic                   pop, push, issue;

    logic [INSTR_WIDTH-1:0] instr_buf_q [BUF_DEPTH];
    logic [PC_WIDTH-1:0]    pc_buf_q    [BUF_DEPTH];
    logic [PC_WIDTH-1:0]    pcn_buf_q   [BUF_DEPTH];

    assign if_valid   = (count_q != '0);
    assign if_instr   = instr_buf_q[head_q];
    assign if_pc      = pc_buf_q[head_q];
    assign if_pc_next = pcn_buf_q[head_q];

    assign im_cen    = ~issue;
    assign im_wen    = 1'b1;
    assign im_oen    = 1'b0;
    assign im_addr   = pc_q[IM_ADDR_WIDTH-1:0];
    assign im_datain = '0;

    always_comb begin
        pop    = if_valid & id_ready;
        push   = inflight_q & ~redirect_valid;
        // Credit counts buffered plus in-flight words, so a full buffer can never overflow.
        credit = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
        issue  = ~rst & ~redirect_valid & (credit < (CNT_W+1)'(BUF_DEPTH));

        pc_d       = pc_q;
        tag_d      = tag_q;
        inflight_d = issue;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;

        if (redirect_valid) begin
            pc_d    = redirect_pc;
            count_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (issue) begin
                pc_d  = pc_q + PC_STEP;
                tag_d = pc_q;
            end
            if (push) tail_d = tail_q + PTR_W'(1);
            if (pop)  head_d = head_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            count_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    // Storage is cleared on reset so the head outputs read zero until the first push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                instr_buf_q[i] <= '0;
                pc_buf_q[i]    <= '0;
                pcn_buf_q[i]   <= '0;
            end
        end else if (push) begin
            instr_buf_q[tail_q] <= im_dataout;
            pc_buf_q[tail_q]    <= tag_q;
            pcn_buf_q[tail_q]   <= tag_q + PC_STEP;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        fetch_cnt_d  = fetch_cnt_q + 32'(pop);
        bubble_cnt_d = bubble_cnt_q + 32'(id_ready & ~if_valid);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            fetch_cnt_q  <= fetch_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign perf_fetch_cnt  = fetch_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: per-cycle vector table, scoreboard run and PC-wrap sequence.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr, if_pc, if_pc_next;
    logic        im_cen, im_wen, im_oen;
    logic [10:0] im_addr;
    logic [31:0] im_datain;
    logic [31:0] im_dataout = '0;

    logic        redir8 = 1'b0;
    logic [7:0]  rpc8 = '0;
    logic        rdy8 = 1'b1;
    logic        vld8;
    logic [31:0] instr8;
    logic [7:0]  pc8, pcn8;
    logic        cen8, wen8, oen8;
    logic [7:0]  addr8;
    logic [31:0] datain8;
    logic [31:0] dout8 = '0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_bubble_cnt, pf8, pb8;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];
    logic        sb_en = 1'b0;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .if_pc_next(if_pc_next), .im_cen(im_cen), .im_wen(im_wen), .im_oen(im_oen),
        .im_addr(im_addr), .im_datain(im_datain), .im_dataout(im_dataout)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
    );

    instruction_fetch_unit #(.PC_WIDTH(8), .IM_ADDR_WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .redirect_valid(redir8), .redirect_pc(rpc8),
        .id_ready(rdy8), .if_valid(vld8), .if_instr(instr8), .if_pc(pc8),
        .if_pc_next(pcn8), .im_cen(cen8), .im_wen(wen8), .im_oen(oen8),
        .im_addr(addr8), .im_datain(datain8), .im_dataout(dout8)
`ifdef IF_PERF_CNT_EN
        , .perf_fetch_cnt(pf8), .perf_bubble_cnt(pb8)
`endif
    );

    // Memories hold word k at address k, read data valid the cycle after the access.
    always @(posedge clk) if (!im_cen) im_dataout <= {21'b0, im_addr};
    always @(posedge clk) if (!cen8) dout8 <= {24'b0, addr8};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, got, exp);
        end
    endtask

    // Scoreboard: each accepted head entry must match the next expected PC.
    always @(negedge clk) begin
        if (sb_en && if_valid && id_ready && !redirect_valid && sb_q.size() > 0) begin
            logic [31:0] e;
            e = sb_q.pop_front();
            chk("sb_pc", if_pc, e);
            chk("sb_instr", if_instr, {21'b0, e[10:0]});
            chk("sb_pc_next", if_pc_next, e + 32'd1);
        end
    end

    task automatic step(input logic r, input logic rdy, input logic rd, input logic [31:0] rpc);
        @(posedge clk);
        #1;
        rst = r;
        id_ready = rdy;
        redirect_valid = rd;
        redirect_pc = rpc;
        @(negedge clk);
    endtask

    typedef struct packed {
        logic        rst;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        cen;
        logic [10:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(logic r, logic rdy, logic rd, logic [31:0] rpc,
                                logic cen, logic [10:0] a, logic v, logic [31:0] pc);
        return {r, rdy, rd, rpc, cen, a, v, pc};
    endfunction

    vec_t tbl[26];

    initial begin
        tbl[0]  = mk(1, 1, 0, 0,        1, 0,       0, 0);
        tbl[1]  = mk(0, 1, 0, 0,        0, 0,       0, 0);
        tbl[2]  = mk(0, 1, 0, 0,        0, 1,       0, 0);
        tbl[3]  = mk(0, 1, 0, 0,        0, 2,       1, 0);
        tbl[4]  = mk(0, 1, 0, 0,        0, 3,       1, 1);
        tbl[5]  = mk(0, 1, 0, 0,        0, 4,       1, 2);
        tbl[6]  = mk(1, 1, 0, 0,        1, 0,       0, 0);
        tbl[7]  = mk(0, 0, 0, 0,        0, 0,       0, 0);
        tbl[8]  = mk(0, 0, 0, 0,        0, 1,       0, 0);
        tbl[9]  = mk(0, 0, 0, 0,        1, 0,       1, 0);
        tbl[10] = mk(0, 0, 0, 0,        1, 0,       1, 0);
        tbl[11] = mk(0, 0, 0, 0,        1, 0,       1, 0);
        tbl[12] = mk(0, 0, 0, 0,        1, 0,       1, 0);
        tbl[13] = mk(0, 1, 0, 0,        0, 2,       1, 0);
        tbl[14] = mk(0, 1, 0, 0,        0, 3,       1, 1);
        tbl[15] = mk(0, 1, 0, 0,        0, 4,       1, 2);
        tbl[16] = mk(0, 0, 1, 'h40,     1, 0,       1, 3);
        tbl[17] = mk(0, 1, 0, 0,        0, 'h40,    0, 0);
        tbl[18] = mk(0, 1, 0, 0,        0, 'h41,    0, 0);
        tbl[19] = mk(0, 1, 0, 0,        0, 'h42,    1, 'h40);
        tbl[20] = mk(0, 1, 0, 0,        0, 'h43,    1, 'h41);
        tbl[21] = mk(0, 1, 1, 'h100,    1, 0,       1, 'h42);
        tbl[22] = mk(0, 1, 1, 'h200,    1, 0,       0, 0);
        tbl[23] = mk(0, 1, 0, 0,        0, 'h200,   0, 0);
        tbl[24] = mk(0, 1, 0, 0,        0, 'h201,   0, 0);
        tbl[25] = mk(0, 1, 0, 0,        0, 'h202,   1, 'h200);

        for (int i = 0; i < 26; i++) begin
            vec_t t;
            t = tbl[i];
            step(t.rst, t.rdy, t.redir, t.rpc);
            chk($sformatf("v%0d_cen", i), {31'b0, im_cen}, {31'b0, t.cen});
            chk($sformatf("v%0d_valid", i), {31'b0, if_valid}, {31'b0, t.vld});
            if (!t.cen) chk($sformatf("v%0d_addr", i), {21'b0, im_addr}, {21'b0, t.addr});
            if (t.vld) begin
                chk($sformatf("v%0d_pc", i), if_pc, t.pc);
                chk($sformatf("v%0d_instr", i), if_instr, {21'b0, t.pc[10:0]});
                chk($sformatf("v%0d_pc_next", i), if_pc_next, t.pc + 32'd1);
            end
            if (t.rst) begin
                chk($sformatf("v%0d_rst_instr", i), if_instr, 32'd0);
                chk($sformatf("v%0d_rst_pc", i), if_pc, 32'd0);
                chk($sformatf("v%0d_rst_pc_next", i), if_pc_next, 32'd0);
                chk($sformatf("v%0d_rst_wen", i), {31'b0, im_wen}, 32'd1);
                chk($sformatf("v%0d_rst_oen", i), {31'b0, im_oen}, 32'd0);
                chk($sformatf("v%0d_rst_datain", i), im_datain, 32'd0);
            end
        end

        // Scoreboard run with random decode back-pressure after a redirect.
        step(0, 1, 1, 32'h10);
        for (int k = 0; k < 40; k++) sb_q.push_back(32'h10 + 32'(k));
        sb_en = 1'b1;
        for (int c = 0; c < 400 && sb_q.size() > 0; c++)
            step(0, 1'($urandom_range(0, 1)), 0, 0);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        sb_en = 1'b0;
        step(0, 0, 0, 0);

        // 8-bit PC wraps from 0xFF to 0x00 on both the fetch address and the head PC.
        @(posedge clk);
        #1;
        redir8 = 1'b1;
        rpc8 = 8'hFF;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            logic [7:0] ea, ep;
            @(posedge clk);
            #1;
            redir8 = 1'b0;
            @(negedge clk);
            ea = 8'hFF + 8'(k);
            ep = 8'hFF + 8'(k - 2);
            if (k < 3) begin
                chk($sformatf("w%0d_cen", k), {31'b0, cen8}, 32'd0);
                chk($sformatf("w%0d_addr", k), {24'b0, addr8}, {24'b0, ea});
            end else begin
                chk($sformatf("w%0d_valid", k), {31'b0, vld8}, 32'd1);
            end
            if (k >= 2) begin
                chk($sformatf("w%0d_pc", k), {24'b0, pc8}, {24'b0, ep});
                chk($sformatf("w%0d_pc_next", k), {24'b0, pcn8}, {24'b0, 8'(ep + 8'd1)});
                chk($sformatf("w%0d_instr", k), instr8, {24'b0, ep});
            end
        end

`ifdef IF_PERF_CNT_EN
        // Two start-up bubbles, ten pops, one bubble after a redirect.
        step(1, 1, 0, 0);
        chk("perf_rst_fetch", perf_fetch_cnt, 32'd0);
        chk("perf_rst_bubble", perf_bubble_cnt, 32'd0);
        for (int c = 0; c < 12; c++) step(0, 1, 0, 0);
        step(0, 0, 1, 32'h40);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        chk("perf_fetch", perf_fetch_cnt, 32'd10);
        chk("perf_bubble", perf_bubble_cnt, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
